// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI read-arbiter constants and FSM state type
package axi_pkg;
   localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY      = 2'b00;
   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin winner select with the last-grant register
module rr_arb2 (
   input  logic       ACLK,
   input  logic       ARESETN,
   input  logic [1:0] req,
   input  logic       upd,
   input  logic       upd_grant,
   output logic       win,
   output logic       any
);
   logic last_grant;
   assign win = (req[0] & req[1]) ? ~last_grant : req[1];
   assign any = |req;
   // reset to 1 so that client 0 wins the first tie
   always_ff @(posedge ACLK or negedge ARESETN)
      if (!ARESETN) last_grant <= 1'b1;
      else if (upd) last_grant <= upd_grant;
endmodule

// File: rtl/axi_rd_arb2.sv
// axi_rd_arb2: shares one AXI4 read master port between two clients, one burst at a time
module axi_rd_arb2
   import axi_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int LEN_W  = 8
) (
   input  logic              ARESETN,
   input  logic              ACLK,
   input  logic [ADDR_W-1:0] S0_ARADDR,
   input  logic [LEN_W-1:0]  S0_ARLEN,
   input  logic              S0_ARVALID,
   output logic              S0_ARREADY,
   output logic [DATA_W-1:0] S0_RDATA,
   output logic [1:0]        S0_RRESP,
   output logic              S0_RLAST,
   output logic              S0_RVALID,
   input  logic              S0_RREADY,
   input  logic [ADDR_W-1:0] S1_ARADDR,
   input  logic [LEN_W-1:0]  S1_ARLEN,
   input  logic              S1_ARVALID,
   output logic              S1_ARREADY,
   output logic [DATA_W-1:0] S1_RDATA,
   output logic [1:0]        S1_RRESP,
   output logic              S1_RLAST,
   output logic              S1_RVALID,
   input  logic              S1_RREADY,
   output logic              M_ARID,
   output logic [ADDR_W-1:0] M_ARADDR,
   output logic [LEN_W-1:0]  M_ARLEN,
   output logic [2:0]        M_ARSIZE,
   output logic [1:0]        M_ARBURST,
   output logic              M_ARVALID,
   input  logic              M_ARREADY,
   input  logic [DATA_W-1:0] M_RDATA,
   input  logic [1:0]        M_RRESP,
   input  logic              M_RLAST,
   input  logic              M_RVALID,
   output logic              M_RREADY,
   output logic              ERR,
   output logic              BUSY
);
   state_t            state;
   logic              grant;
   logic [ADDR_W-1:0] addr;
   logic [LEN_W-1:0]  len;
   logic [LEN_W:0]    beats;
   logic              err;
   logic              win, any, idle, g0, g1, hs_r;
   assign idle = state == IDLE;
   assign g0   = (state == DATA) & ~grant;
   assign g1   = (state == DATA) & grant;
   rr_arb2 u_arb (
      .ACLK      (ACLK),
      .ARESETN   (ARESETN),
      .req       ({S1_ARVALID, S0_ARVALID}),
      .upd       (hs_r & M_RLAST),
      .upd_grant (grant),
      .win       (win),
      .any       (any)
   );
   assign S0_ARREADY = idle & any & ~win;
   assign S1_ARREADY = idle & any & win;
   assign S0_RDATA   = g0 ? M_RDATA : '0;
   assign S0_RRESP   = g0 ? M_RRESP : RESP_OKAY;
   assign S0_RLAST   = g0 & M_RLAST;
   assign S0_RVALID  = g0 & M_RVALID;
   assign S1_RDATA   = g1 ? M_RDATA : '0;
   assign S1_RRESP   = g1 ? M_RRESP : RESP_OKAY;
   assign S1_RLAST   = g1 & M_RLAST;
   assign S1_RVALID  = g1 & M_RVALID;
   assign M_RREADY   = (g0 & S0_RREADY) | (g1 & S1_RREADY);
   assign hs_r       = M_RVALID & M_RREADY;
   assign M_ARID     = grant;
   assign M_ARADDR   = addr;
   assign M_ARLEN    = len;
   assign M_ARSIZE   = AXI_SIZE_8B;
   assign M_ARBURST  = AXI_BURST_INCR;
   assign M_ARVALID  = state == ADDR;
   assign ERR        = err;
   assign BUSY       = ~idle;
   always_ff @(posedge ACLK or negedge ARESETN)
      if (!ARESETN) begin
         state <= IDLE;
         grant <= 1'b0;
         addr  <= '0;
         len   <= '0;
         beats <= '0;
         err   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (any) begin
               state <= ADDR;
               grant <= win;
               addr  <= win ? S1_ARADDR : S0_ARADDR;
               len   <= win ? S1_ARLEN : S0_ARLEN;
            end
            ADDR: if (M_ARREADY) begin
               state <= DATA;
               beats <= '0;
            end
            DATA: if (hs_r) begin
               beats <= beats + 1'b1;
               if (M_RLAST) state <= IDLE;
               // early RLAST, or the ARLEN+1th beat arriving without RLAST
               if (M_RLAST ? (beats != {1'b0, len}) : (beats == {1'b0, len})) err <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
endmodule
